// File: rtl/aes_job_scheduler_pkg.sv
// Shared types and defaults for the AES multi-block job scheduler.
package aes_job_scheduler_pkg;

   localparam int unsigned AES_BLOCK_BYTES   = 16;
   localparam int unsigned AES_SCHED_TIMEOUT = 64;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      START,
      WAIT,
      NEXT,
      FINISH,
      ERROR
   } aes_sched_state_t;

   // Control outputs, all decoded from the scheduler state.
   typedef struct packed {
      logic src_req;
      logic snk_req;
      logic eng_enable;
      logic eng_clear;
      logic eng_start;
      logic busy;
      logic done;
   } aes_sched_out_t;

   // Moore decode of a state into its control outputs.
   function automatic aes_sched_out_t aes_sched_decode(input aes_sched_state_t s);
      aes_sched_out_t o;
      o      = '0;
      o.busy = (s != IDLE);
      unique case (s)
         IDLE:   o.eng_clear = 1'b1;
         REQ: begin
            o.src_req    = 1'b1;
            o.snk_req    = 1'b1;
            o.eng_enable = 1'b1;
         end
         START: begin
            o.eng_start  = 1'b1;
            o.eng_enable = 1'b1;
         end
         WAIT:   o.eng_enable = 1'b1;
         FINISH: o.done = 1'b1;
         ERROR:  o.done = 1'b1;
         default: ;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/aes_job_scheduler_addr_stepper.sv
// Source/sink streamer base address registers: load at job start, advance per block.
module aes_addr_stepper #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned BLOCK_BYTES = 16
) (
   input  logic              clk,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              step_i,
   input  logic [ADDR_W-1:0] src_base_i,
   input  logic [ADDR_W-1:0] dst_base_i,
   output logic [ADDR_W-1:0] src_addr_o,
   output logic [ADDR_W-1:0] dst_addr_o
);

   logic [ADDR_W-1:0] src_q;
   logic [ADDR_W-1:0] dst_q;

   // Address registers; the increment wraps modulo 2^ADDR_W.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         src_q <= '0;
         dst_q <= '0;
      end else if (load_i) begin
         src_q <= src_base_i;
         dst_q <= dst_base_i;
      end else if (step_i) begin
         src_q <= src_q + ADDR_W'(BLOCK_BYTES);
         dst_q <= dst_q + ADDR_W'(BLOCK_BYTES);
      end
   end

   assign src_addr_o = src_q;
   assign dst_addr_o = dst_q;

endmodule

// File: rtl/aes_job_scheduler.sv
// Multi-block AES job scheduler: sequences streamer requests, engine start and
// completion for each block, with per-block timeout and job progress reporting.
module aes_job_scheduler
   import aes_job_scheduler_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned BLOCK_BYTES = AES_BLOCK_BYTES,
   parameter int unsigned TIMEOUT     = AES_SCHED_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] src_base_i,
   input  logic [ADDR_W-1:0] dst_base_i,
   input  logic [CNT_W-1:0]  nb_blocks_i,
   output logic              src_req_start_o,
   output logic [ADDR_W-1:0] src_addr_o,
   input  logic              src_ready_i,
   output logic              snk_req_start_o,
   output logic [ADDR_W-1:0] snk_addr_o,
   input  logic              snk_ready_i,
   input  logic              snk_done_i,
   output logic              eng_enable_o,
   output logic              eng_clear_o,
   output logic              eng_start_o,
   input  logic              eng_done_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [CNT_W-1:0]  blocks_done_o
);

   localparam int unsigned TO_W = $clog2(TIMEOUT);

   aes_sched_state_t  state_q, state_d;
   aes_sched_out_t    out_q;
   logic [CNT_W-1:0]  nb_q;
   logic [CNT_W-1:0]  blocks_q;
   logic [CNT_W-1:0]  blocks_inc;
   logic [TO_W-1:0]   to_cnt_q;
   logic              eng_seen_q, snk_seen_q;
   logic              eng_any, snk_any;
   logic              err_q;
   logic              rst;
   logic              start_acc;

   assign rst       = reset | clear;
   assign start_acc = (state_q == IDLE) && start_i;

   // Next-state logic; done pulses count as seen on the cycle they arrive.
   always_comb begin
      state_d    = state_q;
      eng_any    = eng_seen_q | eng_done_i;
      snk_any    = snk_seen_q | snk_done_i;
      blocks_inc = blocks_q + CNT_W'(1);
      unique case (state_q)
         IDLE:   if (start_i) state_d = (nb_blocks_i == '0) ? FINISH : REQ;
         REQ:    if (src_ready_i && snk_ready_i) state_d = START;
         START:  state_d = WAIT;
         WAIT: begin
            if (eng_any && snk_any)                      state_d = NEXT;
            else if (to_cnt_q == TO_W'(TIMEOUT - 1))     state_d = ERROR;
         end
         NEXT:   state_d = (blocks_inc == nb_q) ? FINISH : REQ;
         FINISH: state_d = IDLE;
         ERROR:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, registered outputs, counters and sticky flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         out_q      <= aes_sched_decode(IDLE);
         nb_q       <= '0;
         blocks_q   <= '0;
         to_cnt_q   <= '0;
         eng_seen_q <= 1'b0;
         snk_seen_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         // Outputs registered from the next state so they track state_q exactly.
         out_q   <= aes_sched_decode(state_d);
         if (start_acc) begin
            nb_q     <= nb_blocks_i;
            blocks_q <= '0;
            err_q    <= 1'b0;
         end
         if (state_d == ERROR)  err_q    <= 1'b1;
         if (state_q == NEXT)   blocks_q <= blocks_inc;
         if (state_q == WAIT) begin
            to_cnt_q   <= to_cnt_q + TO_W'(1);
            eng_seen_q <= eng_any;
            snk_seen_q <= snk_any;
         end else begin
            to_cnt_q   <= '0;
            eng_seen_q <= 1'b0;
            snk_seen_q <= 1'b0;
         end
      end
   end

   aes_addr_stepper #(
      .ADDR_W      (ADDR_W),
      .BLOCK_BYTES (BLOCK_BYTES)
   ) u_addr (
      .clk        (clk),
      .rst_i      (rst),
      .load_i     (start_acc),
      .step_i     (state_q == NEXT),
      .src_base_i (src_base_i),
      .dst_base_i (dst_base_i),
      .src_addr_o (src_addr_o),
      .dst_addr_o (snk_addr_o)
   );

   assign src_req_start_o = out_q.src_req;
   assign snk_req_start_o = out_q.snk_req;
   assign eng_enable_o    = out_q.eng_enable;
   assign eng_clear_o     = out_q.eng_clear;
   assign eng_start_o     = out_q.eng_start;
   assign busy_o          = out_q.busy;
   assign done_o          = out_q.done;
   assign err_o           = err_q;
   assign blocks_done_o   = blocks_q;

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Scoreboard bench for aes_job_scheduler: jobs push expected engine starts and
// job completions; a monitor pops and compares as the DUT presents them.
module tb_aes_job_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clear = 1'b0;
   logic        start_i = 1'b0;
   logic [31:0] src_base_i = '0;
   logic [31:0] dst_base_i = '0;
   logic [15:0] nb_blocks_i = '0;
   logic        src_req_start_o, snk_req_start_o;
   logic [31:0] src_addr_o, snk_addr_o;
   logic        src_ready_i = 1'b1;
   logic        snk_ready_i = 1'b1;
   logic        snk_done_i = 1'b0;
   logic        eng_done_i = 1'b0;
   logic        eng_enable_o, eng_clear_o, eng_start_o;
   logic        busy_o, done_o, err_o;
   logic [15:0] blocks_done_o;

   aes_job_scheduler #(
      .ADDR_W      (32),
      .CNT_W       (16),
      .BLOCK_BYTES (16),
      .TIMEOUT     (8)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .clear           (clear),
      .start_i         (start_i),
      .src_base_i      (src_base_i),
      .dst_base_i      (dst_base_i),
      .nb_blocks_i     (nb_blocks_i),
      .src_req_start_o (src_req_start_o),
      .src_addr_o      (src_addr_o),
      .src_ready_i     (src_ready_i),
      .snk_req_start_o (snk_req_start_o),
      .snk_addr_o      (snk_addr_o),
      .snk_ready_i     (snk_ready_i),
      .snk_done_i      (snk_done_i),
      .eng_enable_o    (eng_enable_o),
      .eng_clear_o     (eng_clear_o),
      .eng_start_o     (eng_start_o),
      .eng_done_i      (eng_done_i),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .err_o           (err_o),
      .blocks_done_o   (blocks_done_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [31:0] a;
      logic [31:0] b;
   } exp_t;

   typedef struct {
      string       name;
      int          nb;
      logic [31:0] src;
      logic [31:0] dst;
      int          ed, sd;       // done pulse delay after WAIT entry, -1 = never
      int          per, off;     // eng_start cycle = off + per*k
      int          nst;          // expected eng_start pulses
      int          done_rel;     // expected done_o cycle, -1 = none
      int          blocks;
      logic        err;
      int          mid;          // cycle of an extra start_i pulse, -1 = none
      int          abort_at;     // cycle clear is raised, -1 = none
      int          rdy_at;       // cycle snk_ready_i rises, -1 = high from start
   } job_t;

   exp_t  start_q[$];
   exp_t  done_q[$];
   int    cyc = 0;
   int    vectors = 0;
   int    miscompares = 0;
   string cur_job = "reset";
   int    eng_dly = 0, snk_dly = 0, eng_cnt = -1, snk_cnt = -1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL [%s] %s: got %0h expected %0h (cycle %0d)", cur_job, n, act, exp, cyc);
      end
   endtask

   // Engine/sink responder: done pulses a programmable number of cycles into WAIT.
   always @(negedge clk) begin
      eng_done_i = 1'b0;
      snk_done_i = 1'b0;
      if (eng_cnt == 0) begin eng_done_i = 1'b1; eng_cnt = -1; end
      else if (eng_cnt > 0) eng_cnt--;
      if (snk_cnt == 0) begin snk_done_i = 1'b1; snk_cnt = -1; end
      else if (snk_cnt > 0) snk_cnt--;
      if (eng_start_o) begin eng_cnt = eng_dly; snk_cnt = snk_dly; end
   end

   // Monitor: compares each engine start and job completion against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (eng_start_o) begin
         if (start_q.size() == 0) chk("unexpected_eng_start", 1, 0);
         else begin
            e = start_q.pop_front();
            chk("eng_start_cycle", cyc, e.cyc);
            chk("src_addr", src_addr_o, e.a);
            chk("snk_addr", snk_addr_o, e.b);
         end
      end
      if (done_o) begin
         if (done_q.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            e = done_q.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("blocks_done", blocks_done_o, e.a);
            chk("err_at_done", err_o, e.b);
         end
      end
   end

   function automatic job_t mk(input string name, input int nb, input logic [31:0] src, dst,
                               input int ed, sd, per, off, nst, done_rel, blocks,
                               input logic err, input int mid, abort_at, rdy_at);
      job_t j;
      j.name = name; j.nb = nb; j.src = src; j.dst = dst; j.ed = ed; j.sd = sd;
      j.per = per; j.off = off; j.nst = nst; j.done_rel = done_rel; j.blocks = blocks;
      j.err = err; j.mid = mid; j.abort_at = abort_at; j.rdy_at = rdy_at;
      return j;
   endfunction

   task automatic run_job(input job_t j);
      int          t0, rel;
      exp_t        e;
      logic [31:0] sa, da;
      cur_job     = j.name;
      eng_dly     = j.ed;
      snk_dly     = j.sd;
      snk_ready_i = (j.rdy_at > 0) ? 1'b0 : 1'b1;
      @(negedge clk);
      t0          = cyc;
      src_base_i  = j.src;
      dst_base_i  = j.dst;
      nb_blocks_i = 16'(j.nb);
      start_i     = 1'b1;
      sa = j.src;
      da = j.dst;
      for (int k = 0; k < j.nst; k++) begin
         e.cyc = t0 + j.off + j.per * k; e.a = sa; e.b = da;
         start_q.push_back(e);
         sa += 32'd16;
         da += 32'd16;
      end
      if (j.done_rel >= 0) begin
         e.cyc = t0 + j.done_rel; e.a = 32'(j.blocks); e.b = {31'd0, j.err};
         done_q.push_back(e);
      end
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         rel     = cyc - t0;
         start_i = (rel == j.mid);
         if (start_i) begin
            src_base_i  = 32'hDEAD0000;
            nb_blocks_i = 16'd5;
         end
         if (rel == 1) begin
            chk("err_cleared_on_start", err_o, 0);
            chk("req_start_cycle1", src_req_start_o, {31'd0, j.nb != 0});
         end
         if (j.rdy_at > 0 && rel < j.rdy_at) begin
            chk("src_req_held", src_req_start_o, 1);
            chk("snk_req_held", snk_req_start_o, 1);
         end
         if (rel == j.rdy_at) snk_ready_i = 1'b1;
         if (rel == j.abort_at) clear = 1'b1;
         if (j.abort_at > 0 && rel == j.abort_at + 1) begin
            clear = 1'b0;
            chk("abort_busy", busy_o, 0);
            chk("abort_blocks", blocks_done_o, 0);
            chk("abort_eng_clear", eng_clear_o, 1);
            chk("abort_src_addr", src_addr_o, 0);
         end
         if (j.abort_at > 0) begin
            if (rel >= j.abort_at + 6) break;
         end else if (done_q.size() == 0) break;
      end
      chk("done_drained", done_q.size(), 0);
      chk("starts_drained", start_q.size(), 0);
      start_q.delete();
      done_q.delete();
      start_i = 1'b0;
      clear   = 1'b0;
      @(negedge clk);
      chk("idle_after_job", busy_o, 0);
      chk("err_sticky", err_o, {31'd0, j.err});
   endtask

   job_t jobs[$];

   initial begin
      jobs.push_back(mk("nominal",       3, 32'h1000, 32'h2000, 0, 0, 4, 2, 3, 13, 3, 0, -1, -1, -1));
      jobs.push_back(mk("zero_len",      0, 32'h3000, 32'h4000, 0, 0, 4, 2, 0,  1, 0, 0, -1, -1, -1));
      jobs.push_back(mk("snk_ready_dly", 1, 32'h5000, 32'h6000, 0, 0, 4, 6, 1,  9, 1, 0, -1, -1,  5));
      jobs.push_back(mk("snk_before_eng",2, 32'h0100, 32'h0200, 3, 0, 7, 2, 2, 15, 2, 0, -1, -1, -1));
      jobs.push_back(mk("same_cycle",    2, 32'h0300, 32'h0400, 0, 0, 4, 2, 2,  9, 2, 0, -1, -1, -1));
      jobs.push_back(mk("eng_before_snk",1, 32'h0500, 32'h0600, 0, 2, 6, 2, 1,  7, 1, 0, -1, -1, -1));
      jobs.push_back(mk("timeout",       1, 32'h0700, 32'h0800,-1, 0, 4, 2, 1, 11, 0, 1, -1, -1, -1));
      jobs.push_back(mk("wrap",          2, 32'hFFFFFFF0, 32'h0, 0, 0, 4, 2, 2,  9, 2, 0, -1, -1, -1));
      jobs.push_back(mk("expiry_edge",   1, 32'h0A00, 32'h0B00, 7, 0,11, 2, 1, 12, 1, 0, -1, -1, -1));
      jobs.push_back(mk("abort",         4, 32'h0C00, 32'h0D00, 0, 0, 4, 2, 2, -1, 0, 0, -1,  7, -1));
      jobs.push_back(mk("ignored_start", 1, 32'h0E00, 32'h0F00, 0, 0, 4, 2, 1,  5, 1, 0,  2, -1, -1));

      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_eng_clear", eng_clear_o, 1);
      chk("rst_eng_enable", eng_enable_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_blocks", blocks_done_o, 0);
      chk("rst_src_addr", src_addr_o, 0);
      chk("rst_snk_addr", snk_addr_o, 0);
      chk("rst_pulses", {29'd0, src_req_start_o, snk_req_start_o, eng_start_o}, 0);

      foreach (jobs[i]) run_job(jobs[i]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
